key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk_mem cycles per debounce sample tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter STABLE_TICKS, default 8, consecutive differing ticks required to accept a key change; legal range 1..15.
REQ-003 clk_mem  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_raw  input  10  board buttons, 1 = pressed, asynchronous to clk_mem, bit order A,B,Select,Start,Right,Left,Up,Down,R,L (bit 0..9).
REQ-006 key_data  output  10  debounced keys, KEYINPUT polarity (1 = released, 0 = pressed), same bit order as btn_raw, registered.
REQ-007 key_event  output  1  one-cycle pulse, registered, high in the cycle key_data takes a new value.

Function
REQ-008 btn_raw SHALL pass through a two-flop synchronizer per bit (btn_sync) before any other use.
REQ-009 A free-running tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert internal tick for exactly the one cycle it holds TICK_DIV-1.
REQ-010 Each key SHALL keep a debounced pressed bit and a 4-bit stability counter, independent of the other keys.
REQ-011 Any cycle btn_sync[i] equals pressed[i], counter i SHALL be cleared to 0, tick or not.
REQ-012 On a tick cycle with btn_sync[i] != pressed[i] and counter i < STABLE_TICKS-1, counter i SHALL increment by 1.
REQ-013 On a tick cycle with btn_sync[i] != pressed[i] and counter i == STABLE_TICKS-1, pressed[i] SHALL toggle and counter i SHALL clear to 0.
REQ-014 Counter arithmetic SHALL never wrap; REQ-013 bounds it at STABLE_TICKS-1.
REQ-015 key_data SHALL equal ~pressed at all times (registered, no extra cycle).
REQ-016 key_event SHALL be 1 in exactly the cycles in which one or more pressed bits changed on the preceding edge; several keys toggling together SHALL give one single-cycle pulse.
REQ-017 Latency from a clean btn_raw edge to key_data change SHALL be 2 synchronizer cycles plus (STABLE_TICKS-1)*TICK_DIV+1 .. STABLE_TICKS*TICK_DIV cycles, depending on tick phase.
REQ-018 A glitch that returns to the debounced level before the STABLE_TICKS-th differing tick SHALL cause no change on key_data or key_event.
REQ-019 With STABLE_TICKS = 1, a key SHALL toggle on the first tick on which it differs.
REQ-020 Simultaneous press of one key and release of another SHALL each be handled by that key's own counter.

Reset
REQ-021 While rst_n = 0: synchronizer flops 0, pressed = 0, all stability counters 0, tick counter 0, key_data = 10'h3FF, key_event = 0.
REQ-022 Reset asserted mid-debounce SHALL discard partial counts; after release, debounce restarts from the REQ-021 state.
REQ-023 First tick after rst_n release SHALL occur TICK_DIV cycles after the first active clock edge.

Verification (TICK_DIV = 4, STABLE_TICKS = 3 unless stated)
REQ-024 Reset: rst_n = 0 with btn_raw = 10'h3FF -> key_data = 10'h3FF, key_event = 0 throughout reset.
REQ-025 Clean press: btn_raw[0] 0->1 and held -> key_data = 10'h3FE after 2 + 9..12 cycles, key_event high exactly 1 cycle; release -> 10'h3FF after same latency, one pulse.
REQ-026 Bounce: btn_raw[3] high for 6 cycles, low 2, high held -> key_data[3] stays 1 until 3 consecutive differing ticks after final rise; exactly one key_event.
REQ-027 Glitch reject: btn_raw[9] high for 7 cycles then low -> key_data stays 10'h3FF, key_event never asserted.
REQ-028 Multi-key: btn_raw = 10'h0F0 in one cycle -> key_data = 10'h30F in one cycle, single key_event pulse.
REQ-029 Reset mid-operation: btn_raw[5] high, rst_n pulsed low after 2 ticks -> key_data[5] = 1 after release; then changes only after full 3-tick debounce from release.

Source files
------------

// File: rtl/key_debounce.sv
// Ten-key button debouncer: two-flop synchronizer, shared sample tick, and a
// per-key stability counter that accepts a change after STABLE_TICKS differing ticks.
module key_debounce #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic       clk_mem,
  input  logic       rst_n,
  input  logic [9:0] btn_raw,
  output logic [9:0] key_data,
  output logic       key_event
);

  localparam int unsigned N_KEYS = 10;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned STAB_W = 4;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

  logic [N_KEYS-1:0]             sync_meta;
  logic [N_KEYS-1:0]             btn_sync;
  logic [TICK_W-1:0]             tick_cnt;
  logic [TICK_W-1:0]             tick_cnt_nxt;
  logic                          tick_c;
  logic [N_KEYS-1:0]             pressed;
  logic [N_KEYS-1:0]             pressed_nxt;
  logic [N_KEYS-1:0][STAB_W-1:0] stab_cnt;
  logic [N_KEYS-1:0][STAB_W-1:0] stab_cnt_nxt;

  // Free-running sample tick
  assign tick_c       = (tick_cnt == TICK_LAST);
  assign tick_cnt_nxt = tick_c ? '0 : tick_cnt + TICK_W'(1);

  // Per-key debounce: any agreement clears the count; the last differing tick toggles
  always_comb begin
    pressed_nxt  = pressed;
    stab_cnt_nxt = stab_cnt;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (btn_sync[i] == pressed[i]) begin
        stab_cnt_nxt[i] = '0;
      end else if (tick_c) begin
        if (stab_cnt[i] == STAB_LAST) begin
          pressed_nxt[i]  = ~pressed[i];
          stab_cnt_nxt[i] = '0;
        end else begin
          stab_cnt_nxt[i] = stab_cnt[i] + STAB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      btn_sync  <= '0;
      tick_cnt  <= '0;
      pressed   <= '0;
      stab_cnt  <= '0;
      key_data  <= '1;
      key_event <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      btn_sync  <= sync_meta;
      tick_cnt  <= tick_cnt_nxt;
      pressed   <= pressed_nxt;
      stab_cnt  <= stab_cnt_nxt;
      // Outputs track the next pressed value so they land on the same edge
      key_data  <= ~pressed_nxt;
      key_event <= (pressed_nxt != pressed);
    end
  end

endmodule
